// File: rtl/scan_pkg.sv
// rtl/scan_pkg.sv - shared FSM state type and default widths for the data-memory scan checker
//
// Purpose : constants and types used by dmem_scan_checker and scan_cmp.
// Ports   : none (package).
package scan_pkg;

  localparam int SCAN_ADDR_W = 10;
  localparam int SCAN_DATA_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_EMIT   = 3'd3,
    ST_FINISH = 3'd4
  } scan_state_t;

endpackage

// File: rtl/scan_cmp.sv
// rtl/scan_cmp.sv - previous-word register plus ordering comparator for the scan checker
//
// Purpose : holds the last captured word and flags when the incoming word is
//           smaller than it. Comparison is signed when SCAN_SIGNED_EN is
//           defined, unsigned otherwise.
// Ports   : clk, reset (sync, active-high)
//           load  - capture strobe; word is stored as the new previous word
//           word  - word being captured this cycle
//           lt    - word < previous word (combinational)
module scan_cmp
  import scan_pkg::*;
#(
  parameter int DATA_W = SCAN_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] word,
  output logic              lt
);

  logic [DATA_W-1:0] prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      prev <= '0;
    end else if (load) begin
      prev <= word;
    end
  end

`ifdef SCAN_SIGNED_EN
  assign lt = $signed(word) < $signed(prev);
`else
  assign lt = word < prev;
`endif

endmodule

// File: rtl/dmem_scan_checker.sv
// rtl/dmem_scan_checker.sv - walks a word array in processor data memory, streams it and checks ordering
//
// Purpose : on start, reads count words from base_addr upward through the
//           processor debug read port, streams each word out with a
//           valid/ready handshake and reports whether the array is
//           non-decreasing and the first index that breaks the order.
// Config  : SCAN_SIGNED_EN selects a signed ordering comparison.
// Ports   : clk, reset (sync, active-high)
//           start, base_addr, count           - scan request
//           inaddress / outdata               - debug read port (RD_LAT cycles)
//           out_valid, out_ready, out_idx, out_data - element stream
//           busy, done, sorted_ok, fail_index - status and result
module dmem_scan_checker
  import scan_pkg::*;
#(
  parameter int ADDR_W = SCAN_ADDR_W,
  parameter int DATA_W = SCAN_DATA_W,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] count,
  output logic [ADDR_W-1:0] inaddress,
  input  logic [DATA_W-1:0] outdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_idx,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done,
  output logic              sorted_ok,
  output logic [ADDR_W-1:0] fail_index
);

  localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  // Last WAIT cycle index; only meaningful when RD_LAT > 0.
  localparam int              WAIT_LAST_I = (RD_LAT > 0) ? RD_LAT - 1 : 0;
  localparam logic [1:0]      WAIT_LAST   = 2'(WAIT_LAST_I);

  scan_state_t state, next_state;

  logic [ADDR_W-1:0] base_r;
  logic [ADDR_W-1:0] count_r;
  logic [ADDR_W-1:0] index;
  logic [ADDR_W-1:0] addr_r;
  logic [1:0]        wait_cnt;

  logic [ADDR_W-1:0] issue_addr;
  logic              start_acc;
  logic              capture;
  logic              last_elem;
  logic              word_lt;

  // Modular address: the ADDR_W-bit sum wraps naturally.
  assign issue_addr = base_r + index;
  assign start_acc  = (state == ST_IDLE) && start;
  assign last_elem  = (index == count_r - ONE);

  // The address is presented combinationally in ISSUE so a zero-latency
  // memory can be sampled in the same cycle; afterwards the registered copy
  // holds it through WAIT, EMIT, FINISH and IDLE.
  assign inaddress = (state == ST_ISSUE) ? issue_addr : addr_r;

  assign capture = (RD_LAT == 0) ? (state == ST_ISSUE)
                                 : ((state == ST_WAIT) && (wait_cnt == WAIT_LAST));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    out_valid  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          next_state = (count == '0) ? ST_FINISH : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        next_state = (RD_LAT == 0) ? ST_EMIT : ST_WAIT;
      end
      ST_WAIT: begin
        if (wait_cnt == WAIT_LAST) begin
          next_state = ST_EMIT;
        end
      end
      ST_EMIT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          next_state = last_elem ? ST_FINISH : ST_ISSUE;
        end
      end
      ST_FINISH: begin
        next_state = ST_IDLE;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  scan_cmp #(
    .DATA_W (DATA_W)
  ) u_cmp (
    .clk   (clk),
    .reset (reset),
    .load  (capture),
    .word  (outdata),
    .lt    (word_lt)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      base_r     <= '0;
      count_r    <= '0;
      index      <= '0;
      addr_r     <= '0;
      wait_cnt   <= '0;
      out_idx    <= '0;
      out_data   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      sorted_ok  <= 1'b0;
      fail_index <= '1;
    end else begin
      // done is registered from FINISH so it appears in the cycle busy drops.
      done <= (state == ST_FINISH);

      if (start_acc) begin
        base_r     <= base_addr;
        count_r    <= count;
        index      <= '0;
        sorted_ok  <= 1'b1;
        fail_index <= '1;
        busy       <= 1'b1;
      end

      if (state == ST_FINISH) begin
        busy <= 1'b0;
      end

      if (state == ST_ISSUE) begin
        addr_r   <= issue_addr;
        wait_cnt <= '0;
      end else if (state == ST_WAIT) begin
        wait_cnt <= wait_cnt + 2'd1;
      end

      if (capture) begin
        out_data <= outdata;
        out_idx  <= index;
        // Element 0 has no predecessor; only the first violation is recorded.
        if ((index != '0) && word_lt) begin
          sorted_ok <= 1'b0;
          if (fail_index == '1) begin
            fail_index <= index;
          end
        end
      end

      if ((state == ST_EMIT) && out_ready && !last_elem) begin
        index <= index + ONE;
      end
    end
  end

endmodule

// File: tb/tb_dmem_scan_checker.sv
// tb/tb_dmem_scan_checker.sv - directed self-checking bench for dmem_scan_checker
module tb_dmem_scan_checker;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [9:0]  base_addr;
  logic [9:0]  count;
  logic [9:0]  inaddress;
  logic [15:0] outdata;
  logic        out_valid;
  logic        out_ready;
  logic [9:0]  out_idx;
  logic [15:0] out_data;
  logic        busy;
  logic        done;
  logic        sorted_ok;
  logic [9:0]  fail_index;

  logic [15:0] mem [0:1023];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // One-cycle read latency memory model.
  always @(posedge clk) outdata <= mem[inaddress];

  dmem_scan_checker dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .count      (count),
    .inaddress  (inaddress),
    .outdata    (outdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_idx    (out_idx),
    .out_data   (out_data),
    .busy       (busy),
    .done       (done),
    .sorted_ok  (sorted_ok),
    .fail_index (fail_index)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // mode 0: out_ready tied high (also checks beat timing); mode 1: ready 1-in-3.
  task automatic run_scan(input int base, input int cnt, input int mode,
                          input int exp_sorted, input int exp_fail);
    int          beats;
    int          dones;
    int          done_cyc;
    logic        stalled;
    logic [9:0]  held_i;
    logic [15:0] held_d;
    beats    = 0;
    dones    = 0;
    done_cyc = -1;
    stalled  = 1'b0;
    held_i   = '0;
    held_d   = '0;
    base_addr = 10'(base);
    count     = 10'(cnt);
    start     = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", busy, 1);
    for (int cyc = 0; cyc < 400 && dones == 0; cyc++) begin
      out_ready = (mode == 0) || (cyc % 3 == 2);
      if (out_valid) begin
        if (stalled) begin
          check("stall_idx", out_idx, held_i);
          check("stall_data", out_data, held_d);
        end else begin
          check("beat_addr", inaddress, (base + beats) % 1024);
        end
        if (out_ready) begin
          if (mode == 0) check("beat_cycle", cyc, 2 + 3 * beats);
          check("beat_idx", out_idx, beats);
          check("beat_data", out_data, mem[(base + beats) % 1024]);
          beats++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held_i  = out_idx;
          held_d  = out_data;
        end
      end
      if (done) begin
        dones++;
        done_cyc = cyc;
      end
      tick();
    end
    out_ready = 1'b1;
    check("done_count", dones, 1);
    check("done_pulse_low", done, 0);
    check("beat_count", beats, cnt);
    if (mode == 0) check("done_cycle", done_cyc, 3 * cnt + 1);
    check("busy_end", busy, 0);
    check("sorted_ok", sorted_ok, exp_sorted);
    check("fail_index", fail_index, exp_fail);
  endtask

  initial begin
    logic seen_done;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    reset     = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    count     = '0;
    out_ready = 1'b1;
    tick();
    tick();
    check("rst_inaddress", inaddress, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_sorted_ok", sorted_ok, 0);
    check("rst_fail_index", fail_index, 10'h3FF);
    reset = 1'b0;
    tick();

    // Sorted 1..10 at 100, ready high.
    for (int i = 0; i < 10; i++) mem[100 + i] = 16'(i + 1);
    run_scan(100, 10, 0, 1, 10'h3FF);

    // 5,3,4,1: first violation at index 1, later one at 3 ignored.
    mem[100] = 16'd5; mem[101] = 16'd3; mem[102] = 16'd4; mem[103] = 16'd1;
    run_scan(100, 4, 0, 0, 1);

    // Empty scan.
    run_scan(100, 0, 0, 1, 10'h3FF);

    // Backpressure 1-in-3 over 1..10.
    for (int i = 0; i < 10; i++) mem[100 + i] = 16'(i + 1);
    run_scan(100, 10, 1, 1, 10'h3FF);

    // 0x0001 then 0xFFFF: order depends on signedness.
    mem[200] = 16'h0001; mem[201] = 16'hFFFF;
`ifdef SCAN_SIGNED_EN
    run_scan(200, 2, 0, 0, 1);
`else
    run_scan(200, 2, 0, 1, 10'h3FF);
`endif

    // Address wrap: 1022,1023,0,1.
    mem[1022] = 16'd10; mem[1023] = 16'd20; mem[0] = 16'd30; mem[1] = 16'd40;
    run_scan(1022, 4, 0, 1, 10'h3FF);

    // Same scan aborted by reset while element 2 is being issued; a start
    // during the scan must be ignored.
    seen_done = 1'b0;
    base_addr = 10'd1022;
    count     = 10'd4;
    start     = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (c == 3) begin
        start     = 1'b1;
        base_addr = 10'd500;
        count     = 10'd1;
      end else begin
        start = 1'b0;
      end
      if (done) seen_done = 1'b1;
      tick();
    end
    start = 1'b0;
    check("abort_issue_addr", inaddress, 0);
    check("abort_busy_before", busy, 1);
    reset = 1'b1;
    tick();
    check("abort_inaddress", inaddress, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_out_idx", out_idx, 0);
    check("abort_out_data", out_data, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_sorted_ok", sorted_ok, 0);
    check("abort_fail_index", fail_index, 10'h3FF);
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (done) seen_done = 1'b1;
      tick();
    end
    check("abort_no_done", seen_done, 0);

    // Fresh scan after the abort.
    mem[100] = 16'd5; mem[101] = 16'd3; mem[102] = 16'd4; mem[103] = 16'd1;
    run_scan(100, 4, 0, 0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_scan_checker.md
DMEM_SCAN_CHECKER -- requirements
Module: dmem_scan_checker

Interface
REQ-001 Parameter ADDR_W, 10, width of the processor debug read address (inaddress).
REQ-002 Parameter DATA_W, 16, width of the processor debug read data (outdata).
REQ-003 Parameter RD_LAT, 1, cycles from inaddress change to valid outdata (legal 0..3).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle pulse; begins a scan when in IDLE.
REQ-007 base_addr  in  ADDR_W  first word address of the array (e.g. 100).
REQ-008 count  in  ADDR_W  number of words to scan.
REQ-009 inaddress  out  ADDR_W  read address driven to risc_processor.
REQ-010 outdata  in  DATA_W  read data returned by risc_processor.
REQ-011 out_valid  out  1  streamed element valid.
REQ-012 out_ready  in  1  downstream accepts element when high with out_valid.
REQ-013 out_idx  out  ADDR_W  element index (0-based) of streamed word.
REQ-014 out_data  out  DATA_W  streamed word.
REQ-015 busy  out  1  high from accepted start until done.
REQ-016 done  out  1  one-cycle pulse at scan completion.
REQ-017 sorted_ok  out  1  scan result: array non-decreasing; held until next start.
REQ-018 fail_index  out  ADDR_W  first index i with data[i] < data[i-1]; all-ones if none.

Function
REQ-019 FSM states IDLE, ISSUE, WAIT, EMIT, FINISH; one-hot or binary is implementation choice.
REQ-020 IDLE: start=1 latches base_addr, count; clears index, sets sorted_ok=1, fail_index=all-ones, busy=1; goes to ISSUE, or FINISH if count==0.
REQ-021 ISSUE: inaddress = (base_addr + index) mod 2^ADDR_W; go to WAIT (RD_LAT>0) or capture outdata same cycle and go to EMIT (RD_LAT==0).
REQ-022 WAIT: hold inaddress for exactly RD_LAT cycles, capture outdata on the last, go to EMIT.
REQ-023 EMIT: out_valid=1, out_data/out_idx stable until out_valid&&out_ready; data never dropped or duplicated.
REQ-024 Compare: for index>0, captured word < previous captured word clears sorted_ok and, if fail_index is all-ones, loads index; later violations do not change fail_index.
REQ-025 On handshake: if index==count-1 go to FINISH, else index+1 and go to ISSUE.
REQ-026 FINISH: done=1 for one cycle, busy=0, return to IDLE; sorted_ok/fail_index held.
REQ-027 start while busy is ignored; start in the FINISH cycle is ignored.
REQ-028 Address wrap-around at 2^ADDR_W is modular, no error.
REQ-029 Minimum per-element latency with out_ready tied high: RD_LAT+2 cycles.
REQ-030 inaddress holds its last value in IDLE and FINISH.

Reset
REQ-031 reset forces IDLE; outputs: inaddress=0, out_valid=0, out_idx=0, out_data=0, busy=0, done=0, sorted_ok=0, fail_index=all-ones.
REQ-032 reset mid-scan aborts without a done pulse; next start begins fresh.

Configuration
REQ-033 Macro SCAN_SIGNED_EN: when defined, REQ-024 comparison is two's-complement signed; when undefined, unsigned.

Structure
REQ-034 Shared package scan_pkg holds the FSM state typedef and the default ADDR_W/DATA_W constants.
REQ-035 One sub-module scan_cmp (registered previous word plus comparator, honouring SCAN_SIGNED_EN) is natural; the FSM stays in the top.

Verification
REQ-036 base 100, count 10, memory 1..10, out_ready=1 -> 10 beats idx 0..9 data 1..10, done once, sorted_ok=1, fail_index=0x3FF.
REQ-037 memory 5,3,4,1 at 100, count 4 -> sorted_ok=0, fail_index=1.
REQ-038 count=0 -> done two cycles after start, no out_valid, sorted_ok=1.
REQ-039 out_ready toggling 1-in-3 -> out_data/out_idx stable while stalled, all 10 words delivered in order.
REQ-040 data 0x0001 then 0xFFFF: unsigned -> sorted_ok=1; SCAN_SIGNED_EN -> sorted_ok=0, fail_index=1.
REQ-041 base 1022, count 4 -> inaddress sequence 1022,1023,0,1; reset at element 2 -> busy=0, no done, outputs at reset values.
